// File: rtl/sha256_compress_rounds.sv
// ---------------------------------------------------------------------------
// sha256_compress_rounds
//
// Runs the 64 SHA-256 compression rounds over a completed message schedule
// (W vector) and adds the result to the incoming chaining value.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous, active-high; clears all state and outputs
//   enable             block enable; low aborts / returns to IDLE
//   w_vector_complete  start qualifier from the W-vector expander
//   w_vector           64 schedule words, word i at [32*i+31:32*i]
//   hash_in            chaining value H0..H7, H0 at [255:224]
//   busy               high in LOAD / ROUND / FINAL
//   round_index        current round t (reads W_LENGTH in FINAL/DONE)
//   hash_out           block hash, H0 at [255:224]; held until next FINAL
//   hash_complete      result valid, high in DONE
//
// Configuration:
//   SHA256_ROUND_UNROLL2_EN  when defined, two chained rounds are evaluated
//                            per ROUND cycle (W_LENGTH must be even).
// ---------------------------------------------------------------------------
module sha256_compress_rounds #(
    parameter int W_LENGTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         w_vector_complete,
    input  logic [32*W_LENGTH-1:0]       w_vector,
    input  logic [255:0]                 hash_in,
    output logic                         busy,
    output logic [$clog2(W_LENGTH):0]    round_index,
    output logic [255:0]                 hash_out,
    output logic                         hash_complete
);

    localparam int IW = $clog2(W_LENGTH);
    localparam int RW = IW + 1;

`ifdef SHA256_ROUND_UNROLL2_EN
    localparam logic [RW-1:0] STEP   = RW'(2);
`else
    localparam logic [RW-1:0] STEP   = RW'(1);
`endif
    // round_index value of the last ROUND cycle
    localparam logic [RW-1:0] LAST_T = RW'(W_LENGTH) - STEP;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [31:0]   w_store [W_LENGTH];
    logic [255:0]  h_store;
    logic [255:0]  work;          // {a,b,c,d,e,f,g,h}, a at [255:224]
    logic [255:0]  round_next;
    logic [255:0]  final_sum;
    logic [IW-1:0] t0_idx;

    // One SHA-256 round on the packed working variables.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] s0, s1, ch, maj, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
        ch  = (e & f) ^ (~e & g);
        t1  = h + s1 + ch + k + w;
        s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
        maj = (a & b) ^ (a & c) ^ (b & c);
        t2  = s0 + maj;
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    assign t0_idx = round_index[IW-1:0];

`ifdef SHA256_ROUND_UNROLL2_EN
    logic [IW-1:0] t1_idx;
    assign t1_idx = t0_idx + IW'(1);

    always_comb begin
        round_next = sha_round(work, K[t0_idx], w_store[t0_idx]);
        round_next = sha_round(round_next, K[t1_idx], w_store[t1_idx]);
    end
`else
    always_comb begin
        round_next = sha_round(work, K[t0_idx], w_store[t0_idx]);
    end
`endif

    // Word-wise feed-forward addition; each 32-bit lane wraps independently.
    always_comb begin
        final_sum = '0;
        for (int i = 0; i < 8; i++) begin
            final_sum[32*i +: 32] = h_store[32*i +: 32] + work[32*i +: 32];
        end
    end

    // Control FSM plus datapath registers. Outputs are all registered; an
    // enable drop in any busy state aborts without touching hash_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            round_index   <= '0;
            hash_out      <= '0;
            hash_complete <= 1'b0;
            work          <= '0;
            h_store       <= '0;
            for (int i = 0; i < W_LENGTH; i++) begin
                w_store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable && w_vector_complete) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        for (int i = 0; i < W_LENGTH; i++) begin
                            w_store[i] <= w_vector[32*i +: 32];
                        end
                        h_store     <= hash_in;
                        work        <= hash_in;
                        round_index <= '0;
                        state       <= ROUND;
                    end
                end
                ROUND: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        work        <= round_next;
                        round_index <= round_index + STEP;
                        if (round_index == LAST_T) begin
                            state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hash_out      <= final_sum;
                        hash_complete <= 1'b1;
                        busy          <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // A held start request is ignored here; restart needs IDLE.
                    if (!enable) begin
                        hash_complete <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    hash_complete <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress_rounds.sv
// ---------------------------------------------------------------------------
// tb_sha256_compress_rounds
//
// Randomized and directed stimulus for sha256_compress_rounds. Expected
// digests come from a loop-based SHA-256 reference model (or from published
// digests); a monitor compares each completed hash and its completion cycle
// against a scoreboard queue filled when the block was started.
// ---------------------------------------------------------------------------
module tb_sha256_compress_rounds;

    localparam int W_LENGTH = 64;
`ifdef SHA256_ROUND_UNROLL2_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 66;
`endif

    localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      enable;
    logic                      w_vector_complete;
    logic [32*W_LENGTH-1:0]    w_vector;
    logic [255:0]              hash_in;
    logic                      busy;
    logic [$clog2(W_LENGTH):0] round_index;
    logic [255:0]              hash_out;
    logic                      hash_complete;

    sha256_compress_rounds #(.W_LENGTH(W_LENGTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .w_vector_complete (w_vector_complete),
        .w_vector          (w_vector),
        .hash_in           (hash_in),
        .busy              (busy),
        .round_index       (round_index),
        .hash_out          (hash_out),
        .hash_complete     (hash_complete)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] digest;
        int           due;
    } exp_t;
    exp_t sb[$];

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message words i at [32*i +: 32]; returns the full 64-word schedule.
    function automatic logic [2047:0] ref_expand(input logic [511:0] m);
        logic [31:0]   w [64];
        logic [2047:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        for (int i = 0; i < 64; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [255:0] ref_compress(input logic [2047:0] wv, input logic [255:0] hin);
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + wv[32*t +: 32];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    exp_t mon_e;
    logic prev_hc = 1'b0;
    always @(negedge clock) begin
        if (hash_complete === 1'b1 && !prev_hc) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_complete: got hash_complete=1 required 0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("digest", hash_out, mon_e.digest);
                checkOutput("complete_cycle", 256'(cyc), 256'(mon_e.due));
            end
        end
        prev_hc <= (hash_complete === 1'b1);
    end

    // ---------------- stimulus ----------------
    // Called at a negedge with the DUT in IDLE; returns one cycle later (LOAD).
    task automatic applyStimulus(input logic [2047:0] w, input logic [255:0] h,
                                 input logic [255:0] expected, input bit push, input bit hold);
        w_vector          = w;
        hash_in           = h;
        enable            = 1'b1;
        w_vector_complete = 1'b1;
        if (push) sb.push_back('{digest: expected, due: cyc + 1 + LAT});
        @(negedge clock);
        checkOutput("busy_after_start", 256'(busy), 256'(1));
        if (!hold) w_vector_complete = 1'b0;
    endtask

    task automatic waitRound(input int target);
        for (int i = 0; i < 200; i++) begin
            if (busy && round_index == 7'(target)) return;
            @(negedge clock);
        end
        total++;
        bad++;
        $display("[TB] FAIL wait_round: got no round %0d required reach within 200 cycles", target);
    endtask

    task automatic waitDone();
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clock);
            if (hash_complete) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL wait_done: got hash_complete=0 required 1 within %0d cycles", LAT + 10);
    endtask

    // Drop enable for one cycle so the DUT returns to IDLE.
    task automatic releaseBlock();
        enable = 1'b0;
        @(negedge clock);
    endtask

    logic [511:0]  msg_abc, msg_empty, msg_rnd;
    logic [2047:0] w_abc, w_empty, w_rnd;
    logic [255:0]  h_rnd, last_digest;
    int            done1;

    initial begin
        reset             = 1'b1;
        enable            = 1'b0;
        w_vector_complete = 1'b0;
        w_vector          = '0;
        hash_in           = '0;

        msg_abc              = '0;
        msg_abc[31:0]        = 32'h61626380;
        msg_abc[32*15 +: 32] = 32'h00000018;
        msg_empty            = '0;
        msg_empty[31:0]      = 32'h80000000;
        w_abc   = ref_expand(msg_abc);
        w_empty = ref_expand(msg_empty);

        repeat (3) @(negedge clock);
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_round_index", 256'(round_index), 256'(0));
        checkOutput("reset_hash_out", hash_out, 256'(0));
        checkOutput("reset_hash_complete", 256'(hash_complete), 256'(0));
        reset = 1'b0;
        @(negedge clock);

        // "abc" and empty-message known answers
        applyStimulus(w_abc, IV, ABC, 1'b1, 1'b0);
        waitDone();
        releaseBlock();
        applyStimulus(w_empty, IV, EMPTY, 1'b1, 1'b0);
        waitDone();
        releaseBlock();

        // random messages and chaining values against the model
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) msg_rnd[32*i +: 32] = $urandom;
            for (int i = 0; i < 8; i++)  h_rnd[32*i +: 32]   = $urandom;
            w_rnd = ref_expand(msg_rnd);
            applyStimulus(w_rnd, h_rnd, ref_compress(w_rnd, h_rnd), 1'b1, 1'b0);
            waitDone();
            last_digest = ref_compress(w_rnd, h_rnd);
            releaseBlock();
        end

        // input isolation: scramble inputs mid-block
        applyStimulus(w_abc, IV, ABC, 1'b1, 1'b0);
        waitRound(10);
        for (int i = 0; i < W_LENGTH; i++) w_vector[32*i +: 32] = $urandom;
        for (int i = 0; i < 8; i++)        hash_in[32*i +: 32]  = $urandom;
        waitDone();
        last_digest = ABC;
        releaseBlock();

        // abort at round 30
        applyStimulus(w_empty, IV, EMPTY, 1'b0, 1'b0);
        waitRound(30);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("abort_busy", 256'(busy), 256'(0));
        checkOutput("abort_hash_complete", 256'(hash_complete), 256'(0));
        checkOutput("abort_hash_out_held", hash_out, last_digest);
        repeat (LAT + 5) @(negedge clock);
        applyStimulus(w_empty, IV, EMPTY, 1'b1, 1'b0);
        waitDone();
        releaseBlock();

        // reset at round 40
        applyStimulus(w_empty, IV, EMPTY, 1'b0, 1'b0);
        waitRound(40);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_busy", 256'(busy), 256'(0));
        checkOutput("midreset_round_index", 256'(round_index), 256'(0));
        checkOutput("midreset_hash_out", hash_out, 256'(0));
        checkOutput("midreset_hash_complete", 256'(hash_complete), 256'(0));
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(w_abc, IV, ABC, 1'b1, 1'b0);
        waitDone();
        releaseBlock();

        // hold in DONE with start still requested, then back-to-back restart
        applyStimulus(w_abc, IV, ABC, 1'b1, 1'b1);
        waitDone();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("hold_hash_complete", 256'(hash_complete), 256'(1));
            checkOutput("hold_busy", 256'(busy), 256'(0));
            checkOutput("hold_hash_out", hash_out, ABC);
        end
        releaseBlock();
        applyStimulus(w_empty, IV, EMPTY, 1'b1, 1'b0);
        waitDone();
        done1 = cyc;
        releaseBlock();
        applyStimulus(w_abc, IV, ABC, 1'b1, 1'b0);
        waitDone();
        checkOutput("b2b_gap", 256'(cyc - done1), 256'(LAT + 2));
        releaseBlock();

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
